// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// Holds the NOP pattern and the fetch FSM state encoding.
package inst_fetch_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory, decoder and control unit.
// master = fetch queue side, slave = environment side.
interface inst_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            halted;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, halted,
    input  imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, halted,
    output imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous FIFO of {pc, inst} entries with flush; flush beats push and pop.
// Pointers wrap naturally; count is one bit wider than the pointers.
module inst_fetch_queue_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == CW'(0));
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: one-outstanding memory fetcher feeding a small queue.
// Handles redirect (flush/refetch, draining a stale in-flight request) and sticky halt.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_queue_if.master bus
);
  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam int              W       = XLEN + 32;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  state_e          r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_saved_pc;
  logic            r_req;

  logic            w_ack;
  logic            w_halt_now;
  logic            w_redir;
  logic            w_flush;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_full;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_count_nxt;
  logic [W-1:0]    w_head;
  logic [XLEN-1:0] w_redirect_pc;

  // ack is only meaningful for an outstanding request; halt outranks redirect
  assign w_ack         = bus.imem_ack && r_req;
  assign w_redirect_pc = bus.redirect_pc & ~XLEN'(3);
  assign w_halt_now    = bus.halt && (r_state != ST_HALT);
  assign w_redir       = bus.redirect_valid && !bus.halt && (r_state != ST_HALT);
  assign w_flush       = w_halt_now || w_redir;
  assign w_push        = (r_state == ST_RUN) && w_ack && !w_flush && !w_full;
  assign w_pop         = !w_empty && bus.inst_ready;
  assign w_count_nxt   = w_flush ? '0 : (w_count + CW'(w_push) - CW'(w_pop));

  inst_fetch_queue_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata ({r_fetch_pc, bus.imem_rdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // fetch FSM: request, fetch address and redirect target tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC;
      r_saved_pc <= RESET_PC;
      r_req      <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_halt_now) begin
            r_state <= ST_HALT;
            r_req   <= r_req && !w_ack;
          end else if (w_redir) begin
            if (r_req && !w_ack) begin
              r_state    <= ST_DRAIN;
              r_saved_pc <= w_redirect_pc;
            end else begin
              r_fetch_pc <= w_redirect_pc;
            end
            r_req <= 1'b1;
          end else begin
            if (w_ack) begin
              r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            r_req <= (r_req && !w_ack) || (w_count_nxt < DEPTH_C);
          end
        end
        ST_DRAIN: begin
          if (w_halt_now) begin
            r_state <= ST_HALT;
            r_req   <= r_req && !w_ack;
          end else if (w_ack) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= w_redir ? w_redirect_pc : r_saved_pc;
            r_req      <= 1'b1;
          end else if (w_redir) begin
            r_saved_pc <= w_redirect_pc;
          end
        end
        ST_HALT: begin
          r_req <= r_req && !w_ack;
        end
        default: begin
          r_state <= ST_HALT;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = r_req;
  assign bus.imem_addr  = r_fetch_pc;
  assign bus.inst_valid = !w_empty;
  assign bus.inst       = w_empty ? NOP_INST : w_head[31:0];
  assign bus.inst_pc    = w_empty ? '0 : w_head[W-1:32];
  assign bus.halted     = (r_state == ST_HALT);
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized self-checking bench for inst_fetch_queue against a queue-based reference model.
// Directed scenarios (latency, full, redirect, halt, async reset, PC wrap) precede a random run.
module tb_inst_fetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          QD  = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  inst_fetch_queue_if #(.XLEN(32)) bus ();

  inst_fetch_queue #(.XLEN(32), .DEPTH(QD), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Reference model: what the fetcher owes the decoder, in plain terms
  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  logic        m_busy;
  logic        m_drop;
  logic [31:0] m_after;
  logic        m_halted;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc     = 32'h0;
    m_busy   = 1'b0;
    m_drop   = 1'b0;
    m_after  = 32'h0;
    m_halted = 1'b0;
  endtask

  task automatic model_update();
    logic        ack;
    logic [31:0] tgt;
    ack = bus.imem_ack && m_busy;
    tgt = {bus.redirect_pc[31:2], 2'b00};
    if (m_halted) begin
      if (ack) m_busy = 1'b0;
    end else if (bus.halt) begin
      m_q.delete();
      m_halted = 1'b1;
      if (ack) m_busy = 1'b0;
    end else if (bus.redirect_valid) begin
      m_q.delete();
      if (m_busy && !ack) begin
        m_drop  = 1'b1;
        m_after = tgt;
      end else begin
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_pc   = tgt;
      end
    end else begin
      if (bus.inst_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (ack) begin
        if (m_drop) begin
          m_drop = 1'b0;
          m_pc   = m_after;
        end else begin
          m_q.push_back({m_pc, bus.imem_rdata});
          m_pc = m_pc + 32'd4;
        end
        m_busy = 1'b0;
      end
    end
    if (!m_halted && !m_busy && m_q.size() < QD) m_busy = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] head;
    head = (m_q.size() != 0) ? m_q[0] : {32'h0, NOP};
    check_val({tag, "_req"}, {63'h0, bus.imem_req}, {63'h0, m_busy});
    if (m_busy) check_val({tag, "_addr"}, {32'h0, bus.imem_addr}, {32'h0, m_pc});
    check_val({tag, "_valid"}, {63'h0, bus.inst_valid}, {63'h0, (m_q.size() != 0)});
    check_val({tag, "_inst"}, {32'h0, bus.inst}, {32'h0, head[31:0]});
    check_val({tag, "_pc"}, {32'h0, bus.inst_pc}, {32'h0, head[63:32]});
    check_val({tag, "_halted"}, {63'h0, bus.halted}, {63'h0, m_halted});
  endtask

  task automatic step(input logic a, input logic r, input logic rv, input logic [31:0] rp,
                      input logic h);
    bus.imem_ack       = a;
    bus.imem_rdata     = $urandom;
    bus.inst_ready     = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.halt           = h;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs("cyc");
  endtask

  // Called just after a falling edge: reset asserts off-edge, mid-cycle
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_req", {63'h0, bus.imem_req}, 64'h0);
    check_val("rst_addr", {32'h0, bus.imem_addr}, 64'h0);
    check_val("rst_valid", {63'h0, bus.inst_valid}, 64'h0);
    check_val("rst_inst", {32'h0, bus.inst}, {32'h0, NOP});
    check_val("rst_pc", {32'h0, bus.inst_pc}, 64'h0);
    check_val("rst_halted", {63'h0, bus.halted}, 64'h0);
    model_reset();
    bus.imem_ack       = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.halt           = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    rst_n              = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.halt           = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // In-order stream; first valid one cycle after first ack
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check_val("t1_first_valid", {63'h0, bus.inst_valid}, 64'h1);
    check_val("t1_first_pc", {32'h0, bus.inst_pc}, 64'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Fill to DEPTH with consumer stalled, then drain
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("t2_full_noreq", {63'h0, bus.imem_req}, 64'h0);
    check_val("t2_full_count", 64'(m_q.size()), 64'd4);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect while request at 0x8 is pending; ack three cycles later
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    check_val("t3_hold_addr", {32'h0, bus.imem_addr}, 64'h8);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("t3_new_addr", {32'h0, bus.imem_addr}, 64'h100);
    check_val("t3_empty", {63'h0, bus.inst_valid}, 64'h0);

    // Redirect with ack in the same cycle; low PC bits ignored
    step(1'b1, 1'b0, 1'b1, 32'h102, 1'b0);
    check_val("t4_addr", {32'h0, bus.imem_addr}, 64'h100);
    check_val("t4_empty", {63'h0, bus.inst_valid}, 64'h0);

    // PC wrap from 0xFFFF_FFFC
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("wrap_addr0", {32'h0, bus.imem_addr}, 64'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("wrap_addr1", {32'h0, bus.imem_addr}, 64'h0);
    check_val("wrap_pc", {32'h0, bus.inst_pc}, 64'hFFFF_FFFC);

    // Halt with same-cycle redirect while a request is pending
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
    check_val("t5_halted", {63'h0, bus.halted}, 64'h1);
    check_val("t5_hold", {63'h0, bus.imem_req}, 64'h1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 32'h0, 1'b0);
    check_val("t5_no_req", {63'h0, bus.imem_req}, 64'h0);

    // Async reset in the middle of an outstanding request
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check_val("t6_restart_pc", {32'h0, bus.inst_pc}, 64'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 499) do_reset();
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 70),
           1'($urandom_range(0, 99) < 4), $urandom, 1'($urandom_range(0, 999) < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
